// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter for fetch and load/store with lane alignment.
// Define FETCH_STARVE_GUARD_EN to bound data-grant runs while fetch waits.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int RAM_LAT      = 1,
  parameter int MAX_DATA_RUN = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_done,
  output logic              if_err,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_ram_mode,
  output logic [31:0]       d_rdata,
  output logic              d_done,
  output logic              d_err,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [3:0]        ram_be,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_CAPT  = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;
  localparam logic [2:0] LAT_M1  = 3'(RAM_LAT - 1);

  logic [2:0]        state;
  logic [2:0]        wcnt;
  logic              sel_d;
  logic              err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        mode_q;
  logic [3:0]        be_q;
  logic [31:0]       wd_q;
  logic [31:0]       rd_q;

  logic [2:0]  f3;
  logic        st;
  logic        d_legal;
  logic        d_mis;
  logic        d_bad;
  logic        if_bad;
  logic [3:0]  d_be;
  logic [31:0] d_wd;
  logic        grant_d;
  logic        grant_f;
  logic        force_f;

  assign f3 = d_ram_mode[3:1];
  assign st = d_ram_mode[0];

  always_comb begin
    d_legal = 1'b0;
    unique case (1'b1)
      st: d_legal = (f3 == 3'b000) ||
                    (f3 == 3'b001) ||
                    (f3 == 3'b010);
      default: d_legal = (f3 != 3'b011) &&
                         (f3 != 3'b110) &&
                         (f3 != 3'b111);
    endcase
  end

  assign d_mis = (f3[1:0] == 2'b01 && d_addr[0]) ||
                 (f3[1:0] == 2'b10 && d_addr[1:0] != 2'b00);
  assign d_bad  = !d_legal || d_mis;
  assign if_bad = (if_addr[1:0] != 2'b00);

  always_comb begin
    d_be = 4'b1111;
    d_wd = d_wdata;
    unique case (1'b1)
      st && f3[1:0] == 2'b00: begin
        d_be = 4'b0001 << d_addr[1:0];
        d_wd = {4{d_wdata[7:0]}};
      end
      st && f3[1:0] == 2'b01: begin
        d_be = d_addr[1] ? 4'b1100 : 4'b0011;
        d_wd = {2{d_wdata[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef FETCH_STARVE_GUARD_EN
  logic [2:0] run_q;

  assign force_f = if_req &&
                   (run_q == 3'(MAX_DATA_RUN));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= '0;
    end else if (state == S_IDLE) begin
      if (!if_req || grant_f) begin
        run_q <= '0;
      end else if (grant_d) begin
        run_q <= run_q + 3'd1;
      end
    end
  end
`else
  assign force_f = 1'b0;
`endif

  assign grant_d = d_req && !force_f;
  assign grant_f = if_req && !grant_d;

  // Align the addressed lane to bit 0 before extension.
  logic [15:0] sh_w;
  logic [31:0] ext;

  assign sh_w = 16'(ram_rdata >> {addr_q[1:0], 3'b000});

  always_comb begin
    ext = ram_rdata;
    unique case (1'b1)
      mode_q[3:1] == 3'b000: ext = {{24{sh_w[7]}}, sh_w[7:0]};
      mode_q[3:1] == 3'b001: ext = {{16{sh_w[15]}}, sh_w};
      mode_q[3:1] == 3'b100: ext = {24'd0, sh_w[7:0]};
      mode_q[3:1] == 3'b101: ext = {16'd0, sh_w};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      wcnt   <= '0;
      sel_d  <= 1'b0;
      err_q  <= 1'b0;
      addr_q <= '0;
      mode_q <= '0;
      be_q   <= '0;
      wd_q   <= '0;
      rd_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_d || grant_f) begin
            sel_d <= grant_d;
            rd_q  <= '0;
            if (grant_d) begin
              addr_q <= d_addr;
              mode_q <= d_ram_mode;
              be_q   <= d_be;
              wd_q   <= d_wd;
              err_q  <= d_bad;
              state  <= d_bad ? S_RESP : S_ISSUE;
            end else begin
              addr_q <= if_addr;
              mode_q <= 4'b0100;
              be_q   <= 4'b1111;
              wd_q   <= '0;
              err_q  <= if_bad;
              state  <= if_bad ? S_RESP : S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          wcnt <= 3'd1;
          if (mode_q[0]) begin
            state <= S_RESP;
          end else if (LAT_M1 == 3'd0) begin
            state <= S_CAPT;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wcnt == LAT_M1) begin
            state <= S_CAPT;
          end else begin
            wcnt <= wcnt + 3'd1;
          end
        end
        S_CAPT: begin
          rd_q  <= ext;
          state <= S_RESP;
        end
        S_RESP: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign ram_en    = (state == S_ISSUE);
  assign ram_we    = ram_en && mode_q[0];
  assign ram_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign ram_be    = be_q;
  assign ram_wdata = wd_q;

  assign if_done  = (state == S_RESP) && !sel_d;
  assign d_done   = (state == S_RESP) && sel_d;
  assign if_err   = if_done && err_q;
  assign d_err    = d_done && err_q;
  assign if_rdata = if_done ? rd_q : '0;
  assign d_rdata  = d_done ? rd_q : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized self-checking bench for mem_port_arbiter.
// Second instance covers RAM_LAT=3 and mid-access reset.
module tb_mem_port_arbiter;

  localparam int LAT  = 1;
  localparam int MAXR = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, rst3_n;
  logic        if_req, if_done, if_err;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_done, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_ram_mode;
  logic        ram_en, ram_we;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic [3:0]  ram_be;

  logic        b_if_req, b_if_done, b_if_err;
  logic [31:0] b_if_addr, b_if_rdata;
  logic        b_d_req, b_d_done, b_d_err;
  logic [31:0] b_d_addr, b_d_wdata, b_d_rdata;
  logic [3:0]  b_d_ram_mode;
  logic        b_ram_en, b_ram_we;
  logic [31:0] b_ram_addr, b_ram_wdata, b_ram_rdata;
  logic [3:0]  b_ram_be;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(
    .ADDR_W(32), .RAM_LAT(LAT), .MAX_DATA_RUN(MAXR)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr),
    .if_rdata(if_rdata), .if_done(if_done),
    .if_err(if_err),
    .d_req(d_req), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ram_mode(d_ram_mode),
    .d_rdata(d_rdata), .d_done(d_done),
    .d_err(d_err),
    .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_be(ram_be),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  mem_port_arbiter #(
    .ADDR_W(32), .RAM_LAT(3), .MAX_DATA_RUN(MAXR)
  ) u3 (
    .clk(clk), .rst_n(rst3_n),
    .if_req(b_if_req), .if_addr(b_if_addr),
    .if_rdata(b_if_rdata), .if_done(b_if_done),
    .if_err(b_if_err),
    .d_req(b_d_req), .d_addr(b_d_addr),
    .d_wdata(b_d_wdata), .d_ram_mode(b_d_ram_mode),
    .d_rdata(b_d_rdata), .d_done(b_d_done),
    .d_err(b_d_err),
    .ram_en(b_ram_en), .ram_we(b_ram_we),
    .ram_addr(b_ram_addr), .ram_be(b_ram_be),
    .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata)
  );

  logic [137:0] outs_a, outs_b;
  assign outs_a = {if_rdata, if_done, if_err, d_rdata,
                   d_done, d_err, ram_en, ram_we,
                   ram_addr, ram_be, ram_wdata};
  assign outs_b = {b_if_rdata, b_if_done, b_if_err,
                   b_d_rdata, b_d_done, b_d_err, b_ram_en,
                   b_ram_we, b_ram_addr, b_ram_be, b_ram_wdata};

  // Reference byte memory and the RAM model's word memory.
  logic [7:0]  ref_mem [256];
  logic [31:0] mem_w   [64];
  logic [31:0] pipe    [8];
  logic [31:0] pipe3   [3];
  logic        poke_en;
  logic [5:0]  poke_idx;
  logic [31:0] poke_val;

  always @(posedge clk) begin
    if (poke_en) mem_w[poke_idx] <= poke_val;
    if (ram_en && ram_we)
      for (int k = 0; k < 4; k++)
        if (ram_be[k])
          mem_w[ram_addr[7:2]][8*k +: 8] <= ram_wdata[8*k +: 8];
    pipe[0] <= (ram_en && !ram_we) ? mem_w[ram_addr[7:2]]
                                   : 32'h5A5A5A5A;
    for (int k = 1; k < 8; k++) pipe[k] <= pipe[k-1];
  end
  assign ram_rdata = pipe[LAT-1];

  function automatic logic [31:0] pat(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  always @(posedge clk) begin
    pipe3[0] <= b_ram_en ? pat(b_ram_addr) : 32'h5A5A5A5A;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign b_ram_rdata = pipe3[2];

  always @(negedge clk) begin
    if (rst_n) begin
      total++;
      if ((if_done && d_done) || (if_err && !if_done) ||
          (d_err && !d_done)) begin
        bad++;
        $display("FAIL excl: if_done=%b d_done=%b if_err=%b d_err=%b",
                 if_done, d_done, if_err, d_err);
      end
    end
  end

  function automatic logic [31:0] ld_val(input logic [2:0] f3,
                                         input logic [7:0] a);
    logic [7:0] b0, b1;
    b0 = ref_mem[a];
    b1 = ref_mem[8'(a + 8'd1)];
    case (f3)
      3'd0: return {{24{b0[7]}}, b0};
      3'd1: return {{16{b1[7]}}, b1, b0};
      3'd4: return {24'd0, b0};
      3'd5: return {16'd0, b1, b0};
      default: return {ref_mem[8'(a + 8'd3)],
                       ref_mem[8'(a + 8'd2)], b1, b0};
    endcase
  endfunction

  task automatic set_word(input logic [7:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) ref_mem[8'(a + 8'(i))] = w[8*i +: 8];
    poke_en  = 1'b1;
    poke_idx = a[7:2];
    poke_val = w;
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  logic [31:0] last_rd, last_wd;
  logic [3:0]  last_be;
  int          last_cyc;

  task automatic do_op(input bit isf, input logic [3:0] mode_in,
                       input logic [7:0] a, input logic [31:0] wd);
    logic [3:0] m;
    logic [2:0] f3;
    logic st, bad_e, we_s, er, done;
    int sz, cyc, ens, ecyc, ncyc, x_ens;
    logic [31:0] ad_s, wd_s, rd, exp_rd, exp_wd, exp_ad;
    logic [3:0] be_s, exp_be;
    m  = isf ? 4'b0100 : mode_in;
    f3 = m[3:1];
    st = m[0];
    sz = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    bad_e = (st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 > 3'd5)) ||
            (sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00);
    if (isf) begin
      if_addr = {24'd0, a};
      if_req  = 1'b1;
    end else begin
      d_addr = {24'd0, a};
      d_ram_mode = m;
      d_wdata = wd;
      d_req = 1'b1;
    end
    cyc = 0; ens = 0; ecyc = 0; done = 0; we_s = 0;
    ad_s = 0; be_s = 0; wd_s = 0; rd = 0; er = 0;
    while (!done && cyc < 40) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (ram_en) begin
        ens++; ecyc = cyc; we_s = ram_we;
        ad_s = ram_addr; be_s = ram_be; wd_s = ram_wdata;
      end
      if (isf ? if_done : d_done) begin
        done = 1;
        rd = isf ? if_rdata : d_rdata;
        er = isf ? if_err : d_err;
      end
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    exp_be = 0; exp_wd = 0; exp_rd = 0;
    if (bad_e) begin
      ncyc = 1;
    end else if (st) begin
      ncyc = 2;
      for (int i = 0; i < sz; i++) exp_be[int'(a[1:0]) + i] = 1'b1;
      for (int k = 0; k < 4; k++) exp_wd[8*k +: 8] = wd[8*(k % sz) +: 8];
    end else begin
      ncyc = 2 + LAT;
      exp_be = 4'hF;
      exp_rd = ld_val(f3, a);
    end
    x_ens  = bad_e ? 0 : 1;
    exp_ad = bad_e ? 32'd0 : {24'd0, a[7:2], 2'b00};
    total++;
    if (!done || cyc != ncyc) begin
      bad++;
      $display("FAIL latency f=%0b m=%b a=%h: done=%0b cyc=%0d want %0d",
               isf, m, a, done, cyc, ncyc);
    end
    total++;
    if (ens != x_ens || ecyc != x_ens || we_s !== (st && !bad_e) ||
        ad_s !== exp_ad || be_s !== exp_be) begin
      bad++;
      $display("FAIL access m=%b a=%h: en=%0d@%0d we=%b addr=%h be=%b want en=%0d we=%b addr=%h be=%b",
               m, a, ens, ecyc, we_s, ad_s, be_s, x_ens,
               st && !bad_e, exp_ad, exp_be);
    end
    if (st && !bad_e) begin
      total++;
      if (wd_s !== exp_wd) begin
        bad++;
        $display("FAIL wdata m=%b a=%h: got %h want %h", m, a, wd_s, exp_wd);
      end
      for (int i = 0; i < sz; i++) ref_mem[8'(a + 8'(i))] = wd[8*i +: 8];
    end
    total++;
    if (er !== bad_e || rd !== exp_rd) begin
      bad++;
      $display("FAIL resp f=%0b m=%b a=%h: err=%b rdata=%h want err=%b rdata=%h",
               isf, m, a, er, rd, bad_e, exp_rd);
    end
    last_rd = rd; last_wd = wd_s; last_be = be_s; last_cyc = cyc;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    total++;
    if (outs_a !== '0) begin
      bad++;
      $display("FAIL reset_outs: got %h want 0", outs_a);
    end
    total++;
    if (outs_b !== '0) begin
      bad++;
      $display("FAIL reset_outs3: got %h want 0", outs_b);
    end
    rst_n = 1'b1;
    rst3_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (outs_a !== '0) begin
      bad++;
      $display("FAIL idle_outs: got %h want 0", outs_a);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_directed;
    set_word(8'h10, 32'hDEADBEEF);
    do_op(0, 4'b0100, 8'h10, 32'd0);
    total++;
    if (last_rd !== 32'hDEADBEEF || last_cyc != 3) begin
      bad++;
      $display("FAIL lw: rdata=%h cyc=%0d want deadbeef 3", last_rd, last_cyc);
    end
    set_word(8'h10, 32'h80112233);
    do_op(0, 4'b0000, 8'h13, 32'd0);
    total++;
    if (last_rd !== 32'hFFFFFF80) begin
      bad++;
      $display("FAIL lb: got %h want ffffff80", last_rd);
    end
    do_op(0, 4'b1000, 8'h13, 32'd0);
    total++;
    if (last_rd !== 32'h00000080) begin
      bad++;
      $display("FAIL lbu: got %h want 00000080", last_rd);
    end
    do_op(0, 4'b0011, 8'h06, 32'h0000ABCD);
    total++;
    if (last_be !== 4'b1100 || last_wd !== 32'hABCDABCD || last_cyc != 2) begin
      bad++;
      $display("FAIL sh: be=%b wdata=%h cyc=%0d want 1100 abcdabcd 2",
               last_be, last_wd, last_cyc);
    end
    do_op(0, 4'b0100, 8'h05, 32'd0);
    do_op(0, 4'b0111, 8'h08, 32'h12345678);
    do_op(1, 4'b0000, 8'h20, 32'd0);
    do_op(1, 4'b0000, 8'h22, 32'd0);
  endtask

  task automatic test_back_to_back;
    bit isf;
    logic [3:0] m;
    logic [7:0] a;
    int sz;
    for (int n = 0; n < 120; n++) begin
      isf = ($urandom_range(0, 3) == 0);
      m = 4'($urandom_range(0, 15));
      sz = (isf || m[2:1] == 2'b10 || m[2:1] == 2'b11) ? 4 :
           (m[2:1] == 2'b01) ? 2 : 1;
      a = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) a = 8'(a & ~(sz - 1));
      do_op(isf, m, a, $urandom);
    end
  endtask

  task automatic test_priority;
    int dl, n, cyc, run, guard;
    bit fp, rd_ok;
    logic [6:0] ord_exp, ord_got;
    logic [31:0] wexp, fexp;
`ifdef FETCH_STARVE_GUARD_EN
    guard = 1;
`else
    guard = 0;
`endif
    run = 0; dl = 6; fp = 1; ord_exp = 0;
    for (int i = 0; i < 7; i++) begin
      if (fp && (dl == 0 || (guard == 1 && run == MAXR))) begin
        ord_exp[i] = 1'b0; fp = 0; run = 0;
      end else begin
        ord_exp[i] = 1'b1; dl--;
        if (fp) run++;
      end
    end
    wexp = ld_val(3'd2, 8'h10);
    fexp = ld_val(3'd2, 8'h20);
    rd_ok = 1;
    d_ram_mode = 4'b0100;
    d_addr = 32'h10;
    if_addr = 32'h20;
    d_req = 1'b1;
    if_req = 1'b1;
    dl = 6; n = 0; cyc = 0; ord_got = 0;
    while (n < 7 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (d_done && n < 7) begin
        ord_got[n] = 1'b1; n++;
        if (d_rdata !== wexp) rd_ok = 0;
        dl--;
        if (dl == 0) d_req = 1'b0;
      end
      if (if_done && n < 7) begin
        ord_got[n] = 1'b0; n++;
        if (if_rdata !== fexp) rd_ok = 0;
        if_req = 1'b0;
      end
    end
    d_req = 1'b0;
    if_req = 1'b0;
    total++;
    if (n != 7 || ord_got !== ord_exp) begin
      bad++;
      $display("FAIL grant_order: got %b (%0d done) want %b",
               ord_got, n, ord_exp);
    end
    total++;
    if (!rd_ok) begin
      bad++;
      $display("FAIL grant_rdata: got bad read data want d=%h f=%h",
               wexp, fexp);
    end
    @(posedge clk); #1;
  endtask

  task automatic b_fetch(input logic [7:0] a, output int cyc,
                         output logic [31:0] rd, output bit done);
    b_if_addr = {24'd0, a};
    b_if_req = 1'b1;
    cyc = 0; done = 0; rd = 0;
    while (!done && cyc < 40) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (b_if_done) begin
        done = 1;
        rd = b_if_rdata;
      end
    end
    b_if_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_lat3_reset;
    int cyc;
    logic [31:0] rd;
    bit done, seen;
    b_fetch(8'h40, cyc, rd, done);
    total++;
    if (!done || cyc != 5 || rd !== pat(32'h40)) begin
      bad++;
      $display("FAIL lat3_fetch: done=%0b cyc=%0d rdata=%h want 5 %h",
               done, cyc, rd, pat(32'h40));
    end
    b_if_addr = 32'h44;
    b_if_req = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    total++;
    if (b_ram_en !== 1'b0 || b_if_done !== 1'b0) begin
      bad++;
      $display("FAIL lat3_wait: ram_en=%b if_done=%b want 0 0",
               b_ram_en, b_if_done);
    end
    #1 rst3_n = 1'b0;
    #1;
    total++;
    if (outs_b !== '0) begin
      bad++;
      $display("FAIL lat3_rst_outs: got %h want 0", outs_b);
    end
    b_if_req = 1'b0;
    seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (b_if_done) seen = 1;
    end
    rst3_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (b_if_done) seen = 1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL lat3_abandon: got if_done want none");
    end
    @(posedge clk); #1;
    b_fetch(8'h48, cyc, rd, done);
    total++;
    if (!done || cyc != 5 || rd !== pat(32'h48)) begin
      bad++;
      $display("FAIL lat3_after_rst: done=%0b cyc=%0d rdata=%h want 5 %h",
               done, cyc, rd, pat(32'h48));
    end
  endtask

  initial begin
    rst_n = 1'b0; rst3_n = 1'b0;
    if_req = 0; if_addr = 0; d_req = 0; d_addr = 0;
    d_wdata = 0; d_ram_mode = 0;
    b_if_req = 0; b_if_addr = 0; b_d_req = 0; b_d_addr = 0;
    b_d_wdata = 0; b_d_ram_mode = 0;
    poke_en = 0; poke_idx = 0; poke_val = 0;
    #1;
    for (int w = 0; w < 64; w++) set_word(8'(w * 4), $urandom);
    test_reset();
    test_directed();
    test_back_to_back();
    test_priority();
    test_lat3_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port instruction/data RAM between the fetch stage and the load/store path driven by the decoder's 4-bit ram_mode (bits [3:1] = funct3, bit [0] = 1 for store).
- Arbitrates between the two requesters and issues exactly one RAM access at a time.
- Generates byte enables and lane-aligned write data, and sign- or zero-extends load data.
- Flags misaligned or illegal accesses without touching the RAM.

Parameters:
- ADDR_W, 32, byte address width.
- RAM_LAT, 1, RAM read latency in cycles from ram_en to valid ram_rdata (1..7).
- MAX_DATA_RUN, 4, consecutive data grants allowed while fetch waits (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request, level; held until if_done.
- if_addr  in  ADDR_W  fetch byte address.
- if_rdata  out  32  fetched word, valid while if_done=1.
- if_done  out  1  one-cycle fetch completion pulse.
- if_err  out  1  fetch misaligned; valid with if_done.
- d_req  in  1  load/store request, level; held until d_done.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  32  store data, low-aligned.
- d_ram_mode  in  4  {funct3, is_store}.
- d_rdata  out  32  extended load data, valid while d_done=1.
- d_done  out  1  one-cycle data completion pulse.
- d_err  out  1  misaligned or illegal mode; valid with d_done.
- ram_en  out  1  RAM access strobe, one cycle.
- ram_we  out  1  write strobe, qualified by ram_en.
- ram_addr  out  ADDR_W  word-aligned address, bits [1:0] = 0.
- ram_be  out  4  byte enables.
- ram_wdata  out  32  lane-replicated write data.
- ram_rdata  in  32  RAM read data.

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low.
  - Reset forces IDLE.
  - All outputs are 0 during reset; counters are 0.
  - Reset mid-transaction abandons the access with no done pulse.
- FSM states:
  - IDLE: evaluate requests.
  - ISSUE: ram_en=1 for exactly one cycle.
  - WAIT: count RAM_LAT-1 cycles; skipped when RAM_LAT=1.
  - CAPTURE: register ram_rdata.
  - RESP: done=1 for one cycle, then IDLE.
- Grant in IDLE only. d_req has priority over if_req. The address, mode and wdata of the granted port are registered at the grant edge.
- Store path: ISSUE→RESP. Load and fetch path: ISSUE→WAIT→CAPTURE→RESP.
- Latency, with the request high at edge 0:
  - store: d_done in cycle 2;
  - read: done in cycle 2+RAM_LAT.
- Requesters deassert req on the edge ending their done cycle. IDLE evaluates the updated level, so back-to-back requests are served with no dead cycle beyond IDLE.
- Legal data modes:
  - loads: funct3 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu;
  - stores: funct3 000 sb, 001 sh, 010 sw;
  - any other mode is illegal.
- Misaligned conditions:
  - half access with addr[0]=1;
  - word access with addr[1:0]≠0;
  - fetch with if_addr[1:0]≠0.
- An illegal or misaligned request goes IDLE→RESP with no ram_en, err=1 and rdata=0.
- Byte enables and write data:
  - sb: be = 1<<addr[1:0], wdata = byte replicated x4;
  - sh: be = addr[1] ? 1100 : 0011, wdata = half replicated x2;
  - sw: be = 1111;
  - loads and fetches: be = 1111, ram_we=0.
- Load extraction: shift the word right by addr[1:0]*8, then sign-extend (lb/lh) or zero-extend (lbu/lhu). lw and fetch pass the word unchanged.
- if_done and d_done are never high in the same cycle. err is 0 whenever its done is 0.

Optional Feature:
- FETCH_STARVE_GUARD_EN defined:
  - A 3-bit run counter increments on each data grant made while if_req=1.
  - It clears on any fetch grant or when if_req=0 in IDLE.
  - When the counter equals MAX_DATA_RUN, the next IDLE grant goes to fetch even if d_req=1.
- Undefined: strict data priority, and no counter is present.

Test Plan:
- lw at 0x0000_0010, ram_rdata=0xDEADBEEF, RAM_LAT=1 -> ram_en in cycle 1 with ram_addr=0x10; d_done in cycle 3 with d_rdata=0xDEADBEEF, d_err=0.
- lb at 0x13 and lbu at 0x13 with word 0x80112233 -> d_rdata=0xFFFFFF80, then 0x00000080.
- sh at 0x06, d_wdata=0x0000ABCD -> ram_be=1100, ram_wdata=0xABCDABCD, ram_we=1; d_done in cycle 2.
- lw at 0x05, then d_ram_mode=0111 (funct3 011 store) -> no ram_en; d_done=1 and d_err=1 one cycle after the request, d_rdata=0.
- if_req and d_req both held high for 6 transactions -> strict priority: 6 data grants before fetch. With FETCH_STARVE_GUARD_EN and MAX_DATA_RUN=4: 4 data grants, then 1 fetch, then data again.
- rst_n pulled low during WAIT of a fetch with RAM_LAT=3 -> outputs 0 immediately, no if_done. A new if_req after release completes normally.
